affine_loop_ctrl: RTL



---
 rtl/affine_loop_ctrl_if.sv | 32 +++
 rtl/affine_loop_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/affine_loop_ctrl_if.sv
// ============================================================================
// Module : affine_loop_ctrl_if
// Brief  : Schedule port between an affine loop controller and a buffer port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface affine_loop_ctrl_if;
  logic        flush;
  logic        stall;
  logic        op_en;
  logic [15:0] op_ctrl_vars [3];
  logic        done;

  modport master (
    input  flush,
    input  stall,
    output op_en,
    output op_ctrl_vars,
    output done
  );

  modport slave (
    output flush,
    output stall,
    input  op_en,
    input  op_ctrl_vars,
    input  done
  );
endinterface

`default_nettype wire

// File: rtl/affine_loop_ctrl.sv
// ============================================================================
// Module : affine_loop_ctrl
// Brief  : Walks a 3-deep loop nest, issuing one strobe plus indices per
//          iteration. Optional macro AFFINE_CTRL_REPEAT_EN repeats frames.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module affine_loop_ctrl #(
  parameter int EXT0        = 1,
  parameter int EXT1        = 64,
  parameter int EXT2        = 64,
  parameter int START_DELAY = 0,
  parameter int II          = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  affine_loop_ctrl_if.master  bus
);

  localparam logic [15:0] c_LAST0      = 16'(EXT0 - 1);
  localparam logic [15:0] c_LAST1      = 16'(EXT1 - 1);
  localparam logic [15:0] c_LAST2      = 16'(EXT2 - 1);
  localparam logic [15:0] c_DELAY_LAST = 16'(START_DELAY);
  localparam logic [7:0]  c_II_LAST    = 8'(II - 1);

  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_issue;
  logic        r_done;
  logic [15:0] r_dcnt;
  logic [7:0]  r_ii;
  logic [15:0] r_vars [3];

  logic [15:0] w_next [3];
  logic        w_wrap1;
  logic        w_wrap2;
  logic        w_last;

  // Wrap tests compare against EXTn-1 so a full 16-bit extent never overflows.
  always_comb begin
    w_wrap2   = (r_vars[2] == c_LAST2);
    w_wrap1   = (r_vars[1] == c_LAST1);
    w_last    = w_wrap2 && w_wrap1 && (r_vars[0] == c_LAST0);
    w_next[2] = w_wrap2 ? 16'd0 : r_vars[2] + 16'd1;
    w_next[1] = r_vars[1];
    w_next[0] = r_vars[0];
    if (w_wrap2) begin
      w_next[1] = w_wrap1 ? 16'd0 : r_vars[1] + 16'd1;
      if (w_wrap1) begin
        w_next[0] = r_vars[0] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state <= S_DELAY;
      r_issue <= 1'b0;
      r_done  <= 1'b0;
      r_dcnt  <= 16'd0;
      r_ii    <= 8'd0;
      r_vars  <= '{default: 16'd0};
    end else begin
`ifdef AFFINE_CTRL_REPEAT_EN
      r_done <= 1'b0;
`endif
      if (!bus.stall) begin
        case (r_state)
          S_DELAY: begin
            if (r_dcnt == c_DELAY_LAST) begin
              r_state <= S_RUN;
              r_issue <= 1'b1;
              r_ii    <= 8'd0;
            end else begin
              r_dcnt <= r_dcnt + 16'd1;
            end
          end
          S_RUN: begin
            if (r_issue) begin
              if (w_last) begin
                r_issue <= 1'b0;
                r_done  <= 1'b1;
`ifdef AFFINE_CTRL_REPEAT_EN
                r_state <= S_DELAY;
                r_dcnt  <= 16'd0;
                r_ii    <= 8'd0;
                r_vars  <= '{default: 16'd0};
`else
                r_state <= S_DONE;
`endif
              end else if (II == 1) begin
                r_vars <= w_next;
              end else begin
                r_issue <= 1'b0;
                r_ii    <= 8'd1;
              end
            end else if (r_ii == c_II_LAST) begin
              // Indices advance only when the next iteration is loaded, so
              // they hold the last issued tuple through the idle gap.
              r_issue <= 1'b1;
              r_vars  <= w_next;
              r_ii    <= 8'd0;
            end else begin
              r_ii <= r_ii + 8'd1;
            end
          end
          default: begin
            r_issue <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.op_en        = r_issue & ~bus.stall;
  assign bus.op_ctrl_vars = r_vars;
  assign bus.done         = r_done;

endmodule

`default_nettype wire
